// File: rtl/sockit_spi_arb_pkg.sv
// Shared types and command-field helpers for the SPI transaction arbiter.
package sockit_spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2,
    DRN  = 2'd3
  } arb_state_t;

  // Command flags sit in the top two bits of a command word of width dw.
  function automatic int cmd_end_pos(input int dw);
    return dw - 1;
  endfunction

  function automatic int cmd_rd_pos(input int dw);
    return dw - 2;
  endfunction

endpackage

// File: rtl/sockit_spi_arb_cnt.sv
// Outstanding-read counter: saturating up/down with full/zero flags and
// a look-ahead of the next value for end-of-transaction decisions.
module sockit_spi_arb_cnt #(
  parameter int OW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [OW-1:0] cnt_nxt,
  output logic          full,
  output logic          zero
);

  localparam logic [OW-1:0] ONE = OW'(1);

  logic [OW-1:0] cnt_q, cnt_d;
  logic          inc_ok, dec_ok;

  always_comb begin
    full   = (cnt_q == '1);
    zero   = (cnt_q == '0);
    inc_ok = inc && !full;
    dec_ok = dec && !zero;
    cnt_d  = cnt_q;
    if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + ONE;
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - ONE;
    end
    cnt_nxt = cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sockit_spi_arb.sv
// Transaction-aware XIP/REG command arbiter with read-data return routing.
// Define SOCKIT_SPI_ARB_RR_EN for round-robin tie-breaking (fixed priority otherwise).
module sockit_spi_arb
  import sockit_spi_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en0,
  input  logic          en1,
  input  logic          scw0_vld,
  output logic          scw0_rdy,
  input  logic [DW-1:0] scw0_dat,
  input  logic          scw1_vld,
  output logic          scw1_rdy,
  input  logic [DW-1:0] scw1_dat,
  input  logic          sdw0_vld,
  output logic          sdw0_rdy,
  input  logic [DW-1:0] sdw0_dat,
  input  logic          sdw1_vld,
  output logic          sdw1_rdy,
  input  logic [DW-1:0] sdw1_dat,
  output logic          sdr0_vld,
  input  logic          sdr0_rdy,
  output logic [DW-1:0] sdr0_dat,
  output logic          sdr1_vld,
  input  logic          sdr1_rdy,
  output logic [DW-1:0] sdr1_dat,
  output logic          scw_vld,
  input  logic          scw_rdy,
  output logic [DW-1:0] scw_dat,
  output logic          sdw_vld,
  input  logic          sdw_rdy,
  output logic [DW-1:0] sdw_dat,
  input  logic          sdr_vld,
  output logic          sdr_rdy,
  input  logic [DW-1:0] sdr_dat,
  output logic          own,
  output logic          busy,
  output logic          err
);

  localparam int CMD_END = cmd_end_pos(DW);
  localparam int CMD_RD  = cmd_rd_pos(DW);

  arb_state_t    state_q, state_d;
  logic          own_q, own_d;
`ifdef SOCKIT_SPI_ARB_RR_EN
  logic          ptr_q, ptr_d;
`endif
  logic          elig0, elig1, win;
  logic          granted, sel, stall;
  logic          cmd_vld;
  logic [DW-1:0] cmd_dat;
  logic          scw_hs, cmd_rd, cmd_end;
  logic          orphan, rd_ret;
  logic [OW-1:0] cnt_nxt;
  logic          cnt_full, cnt_zero;

  sockit_spi_arb_cnt #(.OW(OW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (cmd_rd),
    .dec     (rd_ret),
    .cnt_nxt (cnt_nxt),
    .full    (cnt_full),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
`ifdef SOCKIT_SPI_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
`ifdef SOCKIT_SPI_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
`ifdef SOCKIT_SPI_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    elig0   = scw0_vld && en0;
    elig1   = scw1_vld && en1;
`ifdef SOCKIT_SPI_ARB_RR_EN
    win     = (elig0 && elig1) ? !ptr_q : elig1;
`else
    win     = !elig0;
`endif
    case (state_q)
      IDLE: begin
        // Enables only matter here; a running transaction ignores them.
        if (elig0 || elig1) begin
          own_d   = win;
          state_d = win ? G1 : G0;
`ifdef SOCKIT_SPI_ARB_RR_EN
          ptr_d   = win;
`endif
        end
      end
      G0, G1: begin
        if (cmd_end) begin
          state_d = (cnt_nxt == '0) ? IDLE : DRN;
        end
      end
      DRN: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scw0_rdy = 1'b0;
    scw1_rdy = 1'b0;
    sdw0_rdy = 1'b0;
    sdw1_rdy = 1'b0;
    sdr0_vld = 1'b0;
    sdr1_vld = 1'b0;
    sdr0_dat = '0;
    sdr1_dat = '0;
    scw_vld  = 1'b0;
    scw_dat  = '0;
    sdw_vld  = 1'b0;
    sdw_dat  = '0;
    sdr_rdy  = 1'b0;
    err      = 1'b0;
    granted  = (state_q == G0) || (state_q == G1);
    sel      = (state_q == G1);
    cmd_vld  = sel ? scw1_vld : scw0_vld;
    cmd_dat  = sel ? scw1_dat : scw0_dat;
    // A read command cannot be issued once the return counter is full.
    stall    = cmd_dat[CMD_RD] && cnt_full;
    if (granted) begin
      scw_vld = cmd_vld && !stall;
      scw_dat = cmd_dat;
      sdw_vld = sel ? sdw1_vld : sdw0_vld;
      sdw_dat = sel ? sdw1_dat : sdw0_dat;
      if (sel) begin
        scw1_rdy = scw_rdy && !stall;
        sdw1_rdy = sdw_rdy;
      end else begin
        scw0_rdy = scw_rdy && !stall;
        sdw0_rdy = sdw_rdy;
      end
    end
    scw_hs  = scw_vld && scw_rdy;
    cmd_rd  = scw_hs && cmd_dat[CMD_RD];
    cmd_end = scw_hs && cmd_dat[CMD_END];
    // Beats nobody asked for are sunk and flagged rather than forwarded.
    orphan  = sdr_vld && ((state_q == IDLE) || cnt_zero);
    if (orphan) begin
      sdr_rdy = 1'b1;
      err     = 1'b1;
    end else if (state_q != IDLE) begin
      if (own_q) begin
        sdr1_vld = sdr_vld;
        sdr1_dat = sdr_dat;
        sdr_rdy  = sdr1_rdy;
      end else begin
        sdr0_vld = sdr_vld;
        sdr0_dat = sdr_dat;
        sdr_rdy  = sdr0_rdy;
      end
    end
    rd_ret = sdr_vld && sdr_rdy && !orphan;
    busy   = (state_q != IDLE);
    own    = own_q;
  end

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Scenario bench for sockit_spi_arb; honours SOCKIT_SPI_ARB_RR_EN for the tie winner.
module tb_sockit_spi_arb;
  import sockit_spi_arb_pkg::*;

  localparam int DW = 32;
  localparam int OW = 2;
`ifdef SOCKIT_SPI_ARB_RR_EN
  localparam bit TIE_WIN = 1'b1;
`else
  localparam bit TIE_WIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en0, en1;
  logic scw0_vld, scw0_rdy, scw1_vld, scw1_rdy, scw_vld, scw_rdy;
  logic sdw0_vld, sdw0_rdy, sdw1_vld, sdw1_rdy, sdw_vld, sdw_rdy;
  logic sdr0_vld, sdr0_rdy, sdr1_vld, sdr1_rdy, sdr_vld, sdr_rdy;
  logic [DW-1:0] scw0_dat, scw1_dat, scw_dat, sdw0_dat, sdw1_dat, sdw_dat;
  logic [DW-1:0] sdr0_dat, sdr1_dat, sdr_dat;
  logic own, busy, err;

  int errs = 0;
  int checks = 0;
  logic [DW-1:0] exp_cmd[$];
  logic [DW:0]   exp_rd[$];

  always #5 clk = ~clk;

  sockit_spi_arb #(.DW(DW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .en0(en0), .en1(en1),
    .scw0_vld(scw0_vld), .scw0_rdy(scw0_rdy), .scw0_dat(scw0_dat),
    .scw1_vld(scw1_vld), .scw1_rdy(scw1_rdy), .scw1_dat(scw1_dat),
    .sdw0_vld(sdw0_vld), .sdw0_rdy(sdw0_rdy), .sdw0_dat(sdw0_dat),
    .sdw1_vld(sdw1_vld), .sdw1_rdy(sdw1_rdy), .sdw1_dat(sdw1_dat),
    .sdr0_vld(sdr0_vld), .sdr0_rdy(sdr0_rdy), .sdr0_dat(sdr0_dat),
    .sdr1_vld(sdr1_vld), .sdr1_rdy(sdr1_rdy), .sdr1_dat(sdr1_dat),
    .scw_vld(scw_vld), .scw_rdy(scw_rdy), .scw_dat(scw_dat),
    .sdw_vld(sdw_vld), .sdw_rdy(sdw_rdy), .sdw_dat(sdw_dat),
    .sdr_vld(sdr_vld), .sdr_rdy(sdr_rdy), .sdr_dat(sdr_dat),
    .own(own), .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en0 = 1'b1; en1 = 1'b1;
    scw0_vld = 0; scw1_vld = 0; sdw0_vld = 0; sdw1_vld = 0; sdr_vld = 0;
    scw0_dat = '0; scw1_dat = '0; sdw0_dat = '0; sdw1_dat = '0; sdr_dat = '0;
    scw_rdy = 1; sdw_rdy = 1; sdr0_rdy = 1; sdr1_rdy = 1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Offers one command on port p and waits (bounded) for it to reach the merged output.
  task automatic send_cmd(input bit p, input logic [DW-1:0] d,
                          output bit ok, output logic [DW-1:0] seen, output int cyc);
    ok = 0; seen = '0; cyc = 0;
    if (p) begin scw1_vld = 1; scw1_dat = d; end
    else   begin scw0_vld = 1; scw0_dat = d; end
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (scw_vld && scw_rdy && (p ? scw1_rdy : scw0_rdy)) begin
        ok = 1;
        seen = scw_dat;
      end
      tick();
    end
    if (p) scw1_vld = 0; else scw0_vld = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || own !== 1'b0) begin errs++; $display("FAIL reset_busy_own: got %b%b expected 00", busy, own); end
    checks++; if (scw_vld !== 1'b0 || sdw_vld !== 1'b0) begin errs++; $display("FAIL reset_dn_vld: got %b%b expected 00", scw_vld, sdw_vld); end
    checks++; if (scw0_rdy !== 0 || scw1_rdy !== 0 || sdw0_rdy !== 0 || sdw1_rdy !== 0) begin errs++; $display("FAIL reset_up_rdy: got %b%b%b%b expected 0000", scw0_rdy, scw1_rdy, sdw0_rdy, sdw1_rdy); end
    checks++; if (err !== 1'b0 || dut.u_cnt.cnt_q !== '0) begin errs++; $display("FAIL reset_err_cnt: got err=%b cnt=%0d expected 0 0", err, dut.u_cnt.cnt_q); end
    tick();
  endtask

  task automatic test_single_read();
    bit ok; logic [DW-1:0] seen, e; logic [DW:0] er; int cyc;
    do_reset();
    exp_cmd.push_back(32'h4000_0001);
    send_cmd(0, 32'h4000_0001, ok, seen, cyc);
    e = exp_cmd.pop_front();
    checks++; if (!ok || seen !== e) begin errs++; $display("FAIL rd_cmd: got %h expected %h", seen, e); end
    checks++; if (cyc !== 2) begin errs++; $display("FAIL grant_latency: got %0d expected 2", cyc); end
    sdw0_vld = 1; sdw0_dat = 32'hA5A5_0001; sdw1_vld = 1; sdw1_dat = 32'h5A5A_0002;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || own !== 1'b0) begin errs++; $display("FAIL g0_owner: got busy=%b own=%b expected 1 0", busy, own); end
    checks++; if (sdw_vld !== 1 || sdw_dat !== 32'hA5A5_0001 || sdw0_rdy !== 1 || sdw1_rdy !== 0) begin errs++; $display("FAIL sdw_pass: got %b %h %b%b expected 1 a5a50001 10", sdw_vld, sdw_dat, sdw0_rdy, sdw1_rdy); end
    tick();
    sdw0_vld = 0; sdw1_vld = 0;
    exp_cmd.push_back(32'h8000_0000);
    send_cmd(0, 32'h8000_0000, ok, seen, cyc);
    e = exp_cmd.pop_front();
    checks++; if (!ok || seen !== e) begin errs++; $display("FAIL end_cmd: got %h expected %h", seen, e); end
    @(negedge clk);
    checks++; if (dut.state_q !== DRN || scw0_rdy !== 1'b0) begin errs++; $display("FAIL drain_state: got %0d rdy=%b expected %0d 0", dut.state_q, scw0_rdy, DRN); end
    tick();
    exp_rd.push_back({1'b0, 32'hDEAD_BEEF});
    sdr_vld = 1; sdr_dat = 32'hDEAD_BEEF;
    @(negedge clk);
    er = exp_rd.pop_front();
    checks++; if ((er[DW] ? sdr1_vld : sdr0_vld) !== 1 || (er[DW] ? sdr0_vld : sdr1_vld) !== 0 || sdr0_dat !== er[DW-1:0] || sdr_rdy !== 1 || err !== 0) begin errs++; $display("FAIL rd_route: got vld=%b%b dat=%h rdy=%b err=%b expected port %0d dat %h", sdr1_vld, sdr0_vld, sdr0_dat, sdr_rdy, err, er[DW], er[DW-1:0]); end
    tick();
    sdr_vld = 0; sdr_dat = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL drain_hold: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL drain_release: got %b expected 0", busy); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] e; bit done;
    do_reset();
    if (TIE_WIN) begin exp_cmd.push_back(32'h8000_00B1); exp_cmd.push_back(32'h8000_00A0); end
    else begin exp_cmd.push_back(32'h8000_00A0); exp_cmd.push_back(32'h8000_00B1); end
    scw0_vld = 1; scw0_dat = 32'h8000_00A0; scw1_vld = 1; scw1_dat = 32'h8000_00B1;
    for (int i = 0; i < 20 && exp_cmd.size() > 0; i++) begin
      @(negedge clk);
      if (scw_vld && scw_rdy) begin
        e = exp_cmd.pop_front();
        checks++; if (scw_dat !== e) begin errs++; $display("FAIL tie_order: got %h expected %h", scw_dat, e); end
        checks++; if (own !== e[0]) begin errs++; $display("FAIL tie_owner: got %b expected %b", own, e[0]); end
        done = own;
        tick();
        if (done) scw1_vld = 0; else scw0_vld = 0;
      end else begin
        tick();
      end
    end
    checks++; if (exp_cmd.size() != 0) begin errs++; $display("FAIL tie_timeout: got %0d pending expected 0", exp_cmd.size()); end
    exp_cmd.delete();
    scw0_vld = 0; scw1_vld = 0;
  endtask

  task automatic test_stall();
    bit ok; logic [DW-1:0] seen, e; logic [DW:0] er; int cyc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_cmd.push_back(32'h4000_0010 + DW'(i));
      send_cmd(0, 32'h4000_0010 + DW'(i), ok, seen, cyc);
      e = exp_cmd.pop_front();
      checks++; if (!ok || seen !== e) begin errs++; $display("FAIL fill_cmd: got %h expected %h", seen, e); end
    end
    scw0_vld = 1; scw0_dat = 32'h4000_0013;
    @(negedge clk);
    checks++; if (scw0_rdy !== 0 || scw_vld !== 0) begin errs++; $display("FAIL full_stall: got rdy=%b vld=%b expected 0 0", scw0_rdy, scw_vld); end
    tick();
    exp_rd.push_back({1'b0, 32'hC0DE_0001});
    sdr_vld = 1; sdr_dat = 32'hC0DE_0001;
    @(negedge clk);
    er = exp_rd.pop_front();
    checks++; if (sdr0_vld !== 1 || sdr0_dat !== er[DW-1:0] || scw0_rdy !== 0) begin errs++; $display("FAIL stall_ret: got vld=%b dat=%h rdy=%b expected 1 %h 0", sdr0_vld, sdr0_dat, scw0_rdy, er[DW-1:0]); end
    tick();
    sdr_vld = 0;
    @(negedge clk);
    checks++; if (scw0_rdy !== 1 || scw_vld !== 1 || scw_dat !== 32'h4000_0013) begin errs++; $display("FAIL unstall: got rdy=%b vld=%b dat=%h expected 1 1 40000013", scw0_rdy, scw_vld, scw_dat); end
    tick();
    scw0_vld = 0;
    @(negedge clk);
    checks++; if (dut.u_cnt.cnt_q !== 2'd3) begin errs++; $display("FAIL stall_cnt: got %0d expected 3", dut.u_cnt.cnt_q); end
  endtask

  task automatic test_orphan();
    do_reset();
    sdr_vld = 1; sdr_dat = 32'h1234_5678;
    @(negedge clk);
    checks++; if (sdr_rdy !== 1 || err !== 1 || sdr0_vld !== 0 || sdr1_vld !== 0) begin errs++; $display("FAIL orphan_sink: got rdy=%b err=%b vld=%b%b expected 1 1 00", sdr_rdy, err, sdr1_vld, sdr0_vld); end
    tick();
    sdr_vld = 0;
    @(negedge clk);
    checks++; if (err !== 0 || dut.u_cnt.cnt_q !== '0) begin errs++; $display("FAIL orphan_after: got err=%b cnt=%0d expected 0 0", err, dut.u_cnt.cnt_q); end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [DW-1:0] seen; int cyc;
    do_reset();
    send_cmd(0, 32'h4000_0020, ok, seen, cyc);
    scw0_vld = 1; scw0_dat = 32'h4000_0021; sdr_vld = 1; sdr_dat = 32'hBEEF_0002;
    @(negedge clk);
    checks++; if (scw0_rdy !== 1 || sdr0_vld !== 1 || sdr0_dat !== 32'hBEEF_0002) begin errs++; $display("FAIL simul_hs: got rdy=%b vld=%b dat=%h expected 1 1 beef0002", scw0_rdy, sdr0_vld, sdr0_dat); end
    tick();
    scw0_vld = 0; sdr_vld = 0;
    @(negedge clk);
    checks++; if (dut.u_cnt.cnt_q !== 2'd1) begin errs++; $display("FAIL simul_cnt: got %0d expected 1", dut.u_cnt.cnt_q); end
  endtask

  task automatic test_enable();
    do_reset();
    en0 = 0; scw0_vld = 1; scw0_dat = 32'h8000_0050;
    tick();
    tick();
    @(negedge clk);
    checks++; if (busy !== 0 || scw_vld !== 0) begin errs++; $display("FAIL disabled_port: got busy=%b vld=%b expected 0 0", busy, scw_vld); end
    scw0_vld = 0; en0 = 1;
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok; logic [DW-1:0] seen; int cyc;
    do_reset();
    send_cmd(1, 32'h4000_0030, ok, seen, cyc);
    send_cmd(1, 32'h4000_0031, ok, seen, cyc);
    @(negedge clk);
    checks++; if (own !== 1 || dut.u_cnt.cnt_q !== 2'd2) begin errs++; $display("FAIL g1_setup: got own=%b cnt=%0d expected 1 2", own, dut.u_cnt.cnt_q); end
    tick();
    sdw1_vld = 1; sdw1_dat = 32'h7777_0001;
    rst = 0;
    tick();
    rst = 1;
    @(negedge clk);
    checks++; if (busy !== 0 || own !== 0 || dut.u_cnt.cnt_q !== '0) begin errs++; $display("FAIL rst_state: got busy=%b own=%b cnt=%0d expected 0 0 0", busy, own, dut.u_cnt.cnt_q); end
    checks++; if (scw_vld !== 0 || sdw_vld !== 0 || sdw1_rdy !== 0 || scw1_rdy !== 0 || sdr_rdy !== 0 || sdr1_vld !== 0) begin errs++; $display("FAIL rst_hs: got %b%b%b%b%b%b expected 000000", scw_vld, sdw_vld, sdw1_rdy, scw1_rdy, sdr_rdy, sdr1_vld); end
    checks++; if (scw_dat !== '0 || sdw_dat !== '0 || sdr1_dat !== '0) begin errs++; $display("FAIL rst_dat: got %h %h %h expected 0", scw_dat, sdw_dat, sdr1_dat); end
    tick();
    sdw1_vld = 0;
    send_cmd(0, 32'h8000_0040, ok, seen, cyc);
    checks++; if (!ok || seen !== 32'h8000_0040 || cyc !== 2) begin errs++; $display("FAIL post_rst_grant: got %h in %0d expected 80000040 in 2", seen, cyc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_stall();
    test_orphan();
    test_back_to_back();
    test_enable();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sockit_spi_arb.md
Name: sockit_spi_arb

Overview:
- Transaction-aware arbiter that replaces the static XIP vs REG/DMA select in front of the CDC/pass stage.
- Merges two command streams (port 0 = XIP, port 1 = REG) and two write-data streams (port 0 = XIP, port 1 = DMA) into one downstream set.
- Routes read data back to the port that issued the read.
- Holds the grant from the first command of a transaction until its end command is accepted and all outstanding reads have returned.

Parameters:
- DW, 32, data width of command, write-data and read-data streams.
- OW, 4, width of the outstanding-read counter; maximum in flight is 2^OW-1.

Ports:
- clk  in  1  clock (one clock domain)
- rst  in  1  reset, synchronous, active-low
- en0  in  1  port 0 enable (configuration register)
- en1  in  1  port 1 enable (configuration register)
- scw0_vld/scw0_rdy/scw0_dat  in/out/in  1/1/DW  command, port 0
- scw1_vld/scw1_rdy/scw1_dat  in/out/in  1/1/DW  command, port 1
- sdw0_vld/sdw0_rdy/sdw0_dat  in/out/in  1/1/DW  write data, port 0
- sdw1_vld/sdw1_rdy/sdw1_dat  in/out/in  1/1/DW  write data, port 1
- sdr0_vld/sdr0_rdy/sdr0_dat  out/in/out  1/1/DW  read data, port 0
- sdr1_vld/sdr1_rdy/sdr1_dat  out/in/out  1/1/DW  read data, port 1
- scw_vld/scw_rdy/scw_dat  out/in/out  1/1/DW  merged command, toward CDC
- sdw_vld/sdw_rdy/sdw_dat  out/in/out  1/1/DW  merged write data, toward CDC
- sdr_vld/sdr_rdy/sdr_dat  in/out/in  1/1/DW  read data, from CDC
- own  out  1  current owner (0/1); valid when busy=1
- busy  out  1  grant held
- err  out  1  one-cycle pulse on an orphan read beat

Behaviour:
- Handshake: a transfer occurs when vld&rdy in the same cycle. vld never depends combinationally on rdy.
- Command fields: bit DW-1 END (release slave select, transaction ends); bit DW-2 RD (yields exactly one sdr beat).
- States:
  - IDLE: all upstream rdy=0; downstream vld=0.
  - G0 / G1: grant held by port 0 / port 1.
  - DRN: END accepted; waiting for outstanding reads to return.
- IDLE transitions:
  - Eligible port: vld=1 and enable=1.
  - One eligible port: go to G0 or G1 next cycle (1-cycle arbitration latency).
  - Both eligible: port 0 wins (fixed priority), unless the optional feature is enabled.
  - Command is not consumed in IDLE.
- In Gx (pure combinational pass-through, zero added latency):
  - scw_vld=scwx_vld; scw_dat=scwx_dat; scwx_rdy=scw_rdy.
  - sdw path follows the same rule.
  - Non-owner rdy=0.
  - Command with RD=1 while cnt=2^OW-1: scw_vld and scwx_rdy forced 0 (stall).
- Read-data routing:
  - Always routed to own, in any non-IDLE state: sdrx_vld=sdr_vld, sdrx_dat=sdr_dat, sdr_rdy=sdrx_rdy.
  - The other port's sdr vld=0.
- cnt (OW bits):
  - +1 on an accepted RD command; -1 on an sdr handshake; both in the same cycle leaves it unchanged.
- Orphan read beat (sdr_vld while cnt=0, or state IDLE):
  - sdr_rdy=1 (sink the beat), the beat is dropped, err=1 for that cycle, cnt stays 0.
- END accepted in Gx:
  - cnt after update = 0: go to IDLE.
  - Otherwise: go to DRN (scw/sdw rdy=0).
- DRN: go to IDLE the cycle after cnt reaches 0.
- Enable dropped mid-transaction: ignored until release; enables are sampled only in IDLE.
- Reset mid-operation (rst=0 at a clk edge):
  - State IDLE, cnt=0, own=0, rr pointer=0; busy=0, err=0.
  - All vld/rdy outputs 0 and all dat outputs 0 in the following cycle; in-flight data is discarded.
- Outputs: busy=(state!=IDLE); own is registered on grant.

Optional Feature:
- SOCKIT_SPI_ARB_RR_EN defined:
  - Round-robin; a 1-bit pointer holds the last-granted port.
  - On a both-eligible tie, the other port wins; the pointer updates on every grant.
- Not defined: fixed priority, port 0 always wins; no pointer flop.

Decomposition:
- sockit_spi_pkg additions:
  - Field positions CMD_END=DW-1, CMD_RD=DW-2.
  - Typedef arb_state_t {IDLE,G0,G1,DRN}.
- Sub-module sockit_spi_arb_cnt: saturation-aware up/down outstanding counter with full/zero flags.

Test Plan:
1. Only scw0 valid: cmd 0x4000_0001 (RD) then 0x8000_0000 (END); one sdr beat 0xDEAD_BEEF → grant to port 0 after 1 cycle, state passes through DRN, sdr0 receives 0xDEAD_BEEF, IDLE one cycle later.
2. Both ports valid in IDLE, fixed priority → port 0 served fully, then port 1. With SOCKIT_SPI_ARB_RR_EN: second tie goes to port 1.
3. OW=2, three RD commands without returns → fourth RD command stalls (scw0_rdy=0) until one sdr beat returns.
4. sdr_vld=1 in IDLE with dat 0x1234_5678 → sdr_rdy=1, err pulses once, no sdrx_vld.
5. Simultaneous RD command accept and sdr return at cnt=1 → cnt stays 1.
6. rst=0 while in G1 with cnt=2 → next cycle: busy=0, all vld/rdy=0, cnt=0; new port 0 command granted normally.
